// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the 4-slot TDM demultiplexer
package tdm_pkg;

  localparam int SLOT_COUNT = 4;
  localparam int SLOT_W     = 2;

`ifdef TDM_DEMUX4_PARITY_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SLOT1 = 3'd1,
    SLOT2 = 3'd2,
    SLOT3 = 3'd3,
    PAR   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - slot index counter with clear, load-zero and advance
// load_zero together with advance restarts the count at 1 (resync onto slot 0).
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              load_zero,
  input  logic              advance,
  output logic [SLOT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load_zero) begin
      count <= advance ? SLOT_W'(1) : '0;
    end else if (advance) begin
      count <= count + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM demultiplexer with frame resync
// Optional trailing parity sample enabled by macro TDM_DEMUX4_PARITY_EN.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              frame,
  output logic [DATA_W-1:0] Y0,
  output logic [DATA_W-1:0] Y1,
  output logic [DATA_W-1:0] Y2,
  output logic [DATA_W-1:0] Y3,
  output logic [SLOT_W-1:0] sel,
  output logic              frame_done,
  output logic              sync_err
);

  state_t            state, next_state;
  logic [DATA_W-1:0] shadow [SLOT_COUNT-1];
  logic              store_en, load_y, done_set, err_set;
  logic              cnt_load_zero, cnt_advance;
  logic [SLOT_W-1:0] store_idx;
`ifdef TDM_DEMUX4_PARITY_EN
  logic [DATA_W-1:0] slot3;
  logic              slot3_en;
  logic              parity_ok;

  assign parity_ok = (shadow[0] ^ shadow[1] ^ shadow[2] ^ slot3 ^ din) == '0;
`endif

  // A frame-marked sample always lands in slot 0, whatever slot was expected.
  assign store_idx = frame ? '0 : sel;

  tdm_slot_counter u_slot_counter (
    .clk       (clk),
    .clear     (rst),
    .load_zero (cnt_load_zero),
    .advance   (cnt_advance),
    .count     (sel)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (din_valid) begin
      if (frame) begin
        next_state = SLOT1;
      end else begin
        case (state)
          IDLE:    next_state = IDLE;
          SLOT1:   next_state = SLOT2;
          SLOT2:   next_state = SLOT3;
`ifdef TDM_DEMUX4_PARITY_EN
          SLOT3:   next_state = PAR;
          PAR:     next_state = IDLE;
`else
          SLOT3:   next_state = IDLE;
`endif
          default: next_state = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    store_en      = 1'b0;
    load_y        = 1'b0;
    done_set      = 1'b0;
    err_set       = 1'b0;
    cnt_load_zero = 1'b0;
    cnt_advance   = 1'b0;
`ifdef TDM_DEMUX4_PARITY_EN
    slot3_en      = 1'b0;
`endif
    if (din_valid) begin
      if (frame) begin
        store_en      = 1'b1;
        cnt_advance   = 1'b1;
        err_set       = (state != IDLE);
        cnt_load_zero = (state != IDLE);
      end else begin
        case (state)
          SLOT1, SLOT2: begin
            store_en    = 1'b1;
            cnt_advance = 1'b1;
          end
          SLOT3: begin
            cnt_advance = 1'b1;
`ifdef TDM_DEMUX4_PARITY_EN
            slot3_en    = 1'b1;
`else
            load_y      = 1'b1;
            done_set    = 1'b1;
`endif
          end
`ifdef TDM_DEMUX4_PARITY_EN
          PAR: begin
            cnt_load_zero = 1'b1;
            load_y        = parity_ok;
            done_set      = parity_ok;
            err_set       = !parity_ok;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOT_COUNT - 1; i++) shadow[i] <= '0;
      Y0         <= '0;
      Y1         <= '0;
      Y2         <= '0;
      Y3         <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
`ifdef TDM_DEMUX4_PARITY_EN
      slot3      <= '0;
`endif
    end else begin
      frame_done <= done_set;
      sync_err   <= err_set;
      for (int i = 0; i < SLOT_COUNT - 1; i++) begin
        if (store_en && store_idx == SLOT_W'(i)) shadow[i] <= din;
      end
`ifdef TDM_DEMUX4_PARITY_EN
      if (slot3_en) slot3 <= din;
`endif
      if (load_y) begin
        Y0 <= shadow[0];
        Y1 <= shadow[1];
        Y2 <= shadow[2];
`ifdef TDM_DEMUX4_PARITY_EN
        Y3 <= slot3;
`else
        Y3 <= din;
`endif
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - scoreboard bench for tdm_demux4 against a frame-queue model
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame;
  logic [W-1:0] Y0, Y1, Y2, Y3;
  logic [1:0]   sel;
  logic         frame_done;
  logic         sync_err;

  tdm_demux4 #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame      (frame),
    .Y0         (Y0),
    .Y1         (Y1),
    .Y2         (Y2),
    .Y3         (Y3),
    .sel        (sel),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_done;
    logic [15:0] y;
  } ev_t;

  ev_t          exp_q[$];
  logic [W-1:0] part[$];
  logic [15:0]  y_model;
  logic [15:0]  y_cur;
  logic [1:0]   sel_exp;
  logic         mon_en = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] pack_part();
    return {part[3], part[2], part[1], part[0]};
  endfunction

  // Frame-level reference: the partial frame is a queue of received samples.
  task automatic model_update(input logic v, input logic f, input logic [W-1:0] d);
    logic [W-1:0] par;
    if (v) begin
      if (f) begin
        if (part.size() != 0) exp_q.push_back('{is_done: 1'b0, y: y_model});
        part.delete();
        part.push_back(d);
      end else if (part.size() == 4) begin
        par = part[0] ^ part[1] ^ part[2] ^ part[3];
        if (d == par) begin
          y_model = pack_part();
          exp_q.push_back('{is_done: 1'b1, y: y_model});
        end else begin
          exp_q.push_back('{is_done: 1'b0, y: y_model});
        end
        part.delete();
      end else if (part.size() != 0) begin
        part.push_back(d);
`ifndef TDM_DEMUX4_PARITY_EN
        if (part.size() == 4) begin
          y_model = pack_part();
          exp_q.push_back('{is_done: 1'b1, y: y_model});
          part.delete();
        end
`endif
      end
    end
    sel_exp = 2'(part.size() % 4);
  endtask

  task automatic step(input logic v, input logic f, input logic [W-1:0] d);
    din_valid = v;
    frame     = f;
    din       = d;
    @(posedge clk);
    #1;
    model_update(v, f, d);
  endtask

  task automatic do_reset(input logic v);
    rst       = 1'b1;
    din_valid = v;
    frame     = 1'b1;
    din       = W'($urandom_range(0, 15));
    @(posedge clk);
    #1;
    rst = 1'b0;
    part.delete();
    y_model = '0;
    y_cur   = '0;
    sel_exp = '0;
  endtask

  task automatic send_frame(input logic [W-1:0] a, b, c, e, input int gap);
    logic [W-1:0] s[4];
    s = '{a, b, c, e};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, s[i]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, W'($urandom_range(0, 15)));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ev_t ev;
      check("pulse_exclusive", 32'(frame_done & sync_err), 32'd0);
      if (frame_done || sync_err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", frame_done, sync_err);
        end else begin
          ev = exp_q.pop_front();
          check("pulse_kind_done", 32'(frame_done), 32'(ev.is_done));
          y_cur = ev.y;
        end
      end else if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        n_checks++;
        $display("FAIL missing_pulse: got none expected done=%0b", ev.is_done);
        y_cur = ev.y;
      end
      check("y_outputs", 32'({Y3, Y2, Y1, Y0}), 32'(y_cur));
      check("sel", 32'(sel), 32'(sel_exp));
    end
  end

  initial begin
    logic [W-1:0] d;
    rst = 1'b1; din_valid = 1'b0; frame = 1'b0; din = '0;
    y_model = '0; y_cur = '0; sel_exp = '0;
    @(posedge clk); #1;
    do_reset(1'b1);
    mon_en = 1'b1;

    send_frame(1, 0, 0, 0, 0);
    step(1'b0, 1'b0, 0);
    send_frame(0, 1, 0, 0, 2);
    send_frame(0, 0, 1, 1, 2);

    step(1'b1, 1'b1, 4'h3);
    step(1'b1, 1'b0, 4'h7);
    step(1'b1, 1'b1, 4'h9);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'hc);
    step(1'b0, 1'b0, 0);

    step(1'b1, 1'b1, 4'h6);
    step(1'b1, 1'b0, 4'h8);
    do_reset(1'b1);
    send_frame(1, 0, 1, 0, 0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom_range(0, 15)));

`ifdef TDM_DEMUX4_PARITY_EN
    send_frame(1, 0, 0, 1, 0);
    step(1'b1, 1'b0, 4'h0);
    send_frame(1, 0, 0, 1, 0);
    step(1'b1, 1'b0, 4'h1);
`endif

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        d = W'($urandom_range(0, 15));
        if (part.size() == 4 && $urandom_range(0, 1) == 1)
          d = part[0] ^ part[1] ^ part[2] ^ part[3];
        step($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0, d);
      end
    end

    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
